// File: rtl/stack_pkg.sv
// Shared encodings for the operand-stack sequencer: command ops, FSM states,
// depth-width helper.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PUSH,
    POP,
    CLR
  } state_e;

  // Bits needed to hold a count of 0..d entries.
  function automatic int depth_w(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/stack_bitcnt.sv
// WIDTH-cycle shift counter: start arms it, idx walks 0..WIDTH-1, last flags
// the final shift. Shared by push and pop serialisation.
module stack_bitcnt #(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic act;

  assign last = act && (idx == IW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act <= 1'b0;
      idx <= '0;
    end else if (start) begin
      act <= 1'b1;
      idx <= '0;
    end else if (act) begin
      if (last) act <= 1'b0;
      idx <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/stack_seq.sv
// Sequencer driving DEPTH bit-serial shift-register lanes as an operand stack.
// Build option STACK_SEQ_STICKY_ERR_EN: err holds until CLEAR instead of pulsing.
module stack_seq
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int DW = depth_w(DEPTH),
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [DEPTH-1:0] sr_en,
  output logic             sr_dir,
  output logic             sr_d,
  output logic [DEPTH-1:0] sr_rst,
  input  logic [DEPTH-1:0] sr_lsb,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             err
);

  state_e          state;
  logic [DEPTH-1:0] sel;
  logic [WIDTH-1:0] dsh, asm_w, asm_nxt;
  logic [IW-1:0]    idx;
  logic             last, accept, start, lsb;

  assign full   = (depth == DW'(DEPTH));
  assign empty  = (depth == '0);
  assign accept = cmd_valid && cmd_ready;
  assign start  = accept && (((cmd_op == OP_PUSH) && !full) ||
                             ((cmd_op == OP_POP)  && !empty));
  assign lsb    = |(sr_lsb & sel);

  // Final pop shift lands straight in pop_data without waiting a cycle.
  always_comb begin
    asm_nxt      = asm_w;
    asm_nxt[idx] = lsb;
  end

  stack_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      depth     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      sr_en     <= '0;
      sr_dir    <= 1'b0;
      sr_d      <= 1'b0;
      sr_rst    <= '0;
      sel       <= '0;
      dsh       <= '0;
      asm_w     <= '0;
    end else begin
      pop_valid <= 1'b0;
`ifndef STACK_SEQ_STICKY_ERR_EN
      err       <= 1'b0;
`endif
      case (state)
        INIT: begin
          sr_rst <= '1;
          state  <= CLR;
        end
        CLR: begin
          sr_rst    <= '0;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        IDLE: if (accept) begin
          case (op_e'(cmd_op))
            OP_PUSH: if (full) err <= 1'b1;
            else begin
              sel       <= DEPTH'(1) << depth;
              sr_en     <= DEPTH'(1) << depth;
              sr_dir    <= 1'b0;
              sr_d      <= cmd_data[WIDTH-1];
              dsh       <= cmd_data << 1;
              state     <= PUSH;
              cmd_ready <= 1'b0;
            end
            OP_POP: if (empty) err <= 1'b1;
            else begin
              sel       <= DEPTH'(1) << (depth - DW'(1));
              sr_en     <= DEPTH'(1) << (depth - DW'(1));
              sr_dir    <= 1'b1;
              state     <= POP;
              cmd_ready <= 1'b0;
            end
            OP_CLEAR: begin
              sr_rst    <= '1;
              depth     <= '0;
              state     <= CLR;
              cmd_ready <= 1'b0;
`ifdef STACK_SEQ_STICKY_ERR_EN
              err       <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
        PUSH: begin
          sr_d <= dsh[WIDTH-1];
          dsh  <= dsh << 1;
          if (last) begin
            sr_en     <= '0;
            sr_d      <= 1'b0;
            depth     <= depth + DW'(1);
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        POP: begin
          asm_w <= asm_nxt;
          if (last) begin
            sr_en     <= '0;
            sr_dir    <= 1'b0;
            pop_data  <= asm_nxt;
            pop_valid <= 1'b1;
            depth     <= depth - DW'(1);
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
